// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the triple-buffer frame scheduler.
package frame_scheduler_pkg;

   localparam int NUM_FB = 3;

   typedef logic [1:0] buf_idx_t;

   typedef enum logic [1:0] {
      S_START   = 2'd0,
      S_WAITLOW = 2'd1,
      S_RENDER  = 2'd2,
      S_STALL   = 2'd3
   } sched_state_t;

   // The three roles always form a permutation of {0,1,2}, so the third
   // buffer is whatever index the other two leave over.
   function automatic buf_idx_t free_buf(buf_idx_t a, buf_idx_t b);
      return buf_idx_t'(NUM_FB - int'(a) - int'(b));
   endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Renderer / scan-out handshake and statistics bundle of the frame scheduler.
interface frame_scheduler_if
   import frame_scheduler_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic             new_frame;
   logic             vsync_lock;
   logic             render_done;
   logic             render_ack;
   logic             render_go;
   buf_idx_t         display_buf;
   buf_idx_t         render_buf;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] repeat_count;
   logic [CNT_W-1:0] drop_count;

   // Scheduler side.
   modport master (
      input  new_frame, vsync_lock, render_done,
      output render_ack, render_go, display_buf, render_buf,
             frame_count, repeat_count, drop_count
   );

   // Renderer / output-path side.
   modport slave (
      output new_frame, vsync_lock, render_done,
      input  render_ack, render_go, display_buf, render_buf,
             frame_count, repeat_count, drop_count
   );
endinterface

// File: rtl/frame_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Count events, holding at the maximum instead of wrapping.
   always_ff @(posedge Clk) begin
      // NOTE: registers are assigned with <= so every flop samples the
      // pre-edge values, independent of statement order.
      if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/frame_scheduler.sv
// Triple-buffer frame scheduler: rotates display/ready/render roles across
// three framebuffers and sequences the renderer handshake.
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   frame_scheduler_if.master   bus
);

   buf_idx_t         display_q;
   buf_idx_t         render_q;
   buf_idx_t         ready_q;
   logic             ready_valid_q;
   sched_state_t     state_q;
   logic             go_q;
   logic             ack_q;
   logic [CNT_W-1:0] frame_q;
   logic [CNT_W-1:0] repeat_cnt;
   logic [CNT_W-1:0] drop_cnt;

   // Values after this cycle's display swap; the completion step builds on them.
   buf_idx_t display_d;
   buf_idx_t swap_ready;
   logic     swap_valid;
   logic     frame_inc;
   logic     repeat_inc;
   logic     complete;
   logic     stall;
   logic     accept;
   logic     drop_inc;

   // Display swap first, then decide whether a finished frame is accepted.
   always_comb begin
      // NOTE: every combinational output gets a default up front so no path
      // leaves it unassigned, which would otherwise infer a latch.
      display_d  = display_q;
      swap_ready = ready_q;
      swap_valid = ready_valid_q;
      frame_inc  = 1'b0;
      repeat_inc = 1'b0;
      if (bus.new_frame) begin
         if (ready_valid_q) begin
            display_d  = ready_q;
            swap_ready = display_q;
            swap_valid = 1'b0;
            frame_inc  = 1'b1;
         end else begin
            repeat_inc = 1'b1;
         end
      end
      // A stalled frame is re-offered every cycle; a rendering one only on done.
      complete = ((state_q == S_RENDER) && bus.render_done) || (state_q == S_STALL);
      // FIFO mode refuses to overwrite a frame that is still waiting.
      stall    = complete && bus.vsync_lock && swap_valid;
      accept   = complete && !stall;
      // Accepting over a still-waiting frame (mailbox mode) loses that frame.
      drop_inc = accept && swap_valid;
   end

   // Renderer FSM together with buffer roles and registered handshake outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         display_q     <= buf_idx_t'(0);
         render_q      <= buf_idx_t'(1);
         ready_q       <= buf_idx_t'(2);
         ready_valid_q <= 1'b0;
         state_q       <= S_START;
         go_q          <= 1'b0;
         ack_q         <= 1'b0;
         frame_q       <= '0;
      end else begin
         // NOTE: pulses and swap results are assigned first as defaults; a later
         // <= to the same register in the case below overrides them.
         go_q          <= 1'b0;
         ack_q         <= 1'b0;
         display_q     <= display_d;
         ready_q       <= swap_ready;
         ready_valid_q <= swap_valid;
         if (frame_inc) begin
            frame_q <= frame_q + 1'b1;
         end
         case (state_q)
            S_START: begin
               go_q    <= 1'b1;
               state_q <= S_RENDER;
            end
            S_RENDER, S_STALL: begin
               if (accept) begin
                  ready_q       <= render_q;
                  ready_valid_q <= 1'b1;
                  render_q      <= free_buf(display_d, render_q);
                  ack_q         <= 1'b1;
                  state_q       <= S_WAITLOW;
               end else if (stall) begin
                  state_q <= S_STALL;
               end
            end
            S_WAITLOW: begin
               if (!bus.render_done) begin
                  state_q <= S_START;
               end
            end
            default: state_q <= S_START;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_repeat_cnt (
      .Clk     (Clk),
      .clr     (Reset),
      .inc     (repeat_inc),
      .count_o (repeat_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
      .Clk     (Clk),
      .clr     (Reset),
      .inc     (drop_inc),
      .count_o (drop_cnt)
   );

   assign bus.render_go    = go_q;
   assign bus.render_ack   = ack_q;
   assign bus.display_buf  = display_q;
   assign bus.render_buf   = render_q;
   assign bus.frame_count  = frame_q;
   assign bus.repeat_count = repeat_cnt;
   assign bus.drop_count   = drop_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against a role-based reference model.
module tb_frame_scheduler;
   import frame_scheduler_pkg::*;

   // Narrow counters so saturation and wrap-around are reached in a few cycles.
   localparam int CNT_W   = 4;
   localparam int CNT_MOD = 1 << CNT_W;
   localparam int CNT_MAX = CNT_MOD - 1;

   logic Clk = 1'b0;
   logic Reset;

   frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

   frame_scheduler #(.CNT_W(CNT_W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #10 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: roles per buffer ----------------
   typedef enum int {R_DISP, R_READY, R_RENDER} role_e;
   typedef enum int {P_GO, P_DRAW, P_BLOCKED, P_RELEASE} phase_e;

   role_e  role [3];
   bit     m_waiting;
   phase_e m_phase;
   int     m_go, m_ack, m_frame, m_rep, m_drop;

   function automatic int owner(input role_e r);
      for (int b = 0; b < 3; b++) if (role[b] == r) return b;
      return -1;
   endfunction

   task automatic trade(input role_e a, input role_e b);
      for (int i = 0; i < 3; i++) begin
         if (role[i] == a) role[i] = b;
         else if (role[i] == b) role[i] = a;
      end
   endtask

   // Advance the model by one clock using the inputs the DUT is about to sample.
   task automatic model_step();
      phase_e ph;
      if (Reset) begin
         role[0] = R_DISP; role[1] = R_RENDER; role[2] = R_READY;
         m_waiting = 0; m_phase = P_GO;
         m_go = 0; m_ack = 0; m_frame = 0; m_rep = 0; m_drop = 0;
         return;
      end
      m_go = 0; m_ack = 0;
      if (bus.new_frame) begin
         if (m_waiting) begin
            trade(R_DISP, R_READY);
            m_waiting = 0;
            m_frame = (m_frame + 1) % CNT_MOD;
         end else begin
            m_rep = (m_rep < CNT_MAX) ? m_rep + 1 : CNT_MAX;
         end
      end
      ph = m_phase;
      case (ph)
         P_GO: begin m_go = 1; m_phase = P_DRAW; end
         P_DRAW, P_BLOCKED: begin
            if (ph == P_BLOCKED || bus.render_done) begin
               if (bus.vsync_lock && m_waiting) begin
                  m_phase = P_BLOCKED;
               end else begin
                  if (m_waiting) m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX;
                  trade(R_RENDER, R_READY);
                  m_waiting = 1;
                  m_ack = 1;
                  m_phase = P_RELEASE;
               end
            end
         end
         P_RELEASE: if (!bus.render_done) m_phase = P_GO;
         default: ;
      endcase
   endtask

   task automatic compare_model();
      int d, r, q;
      d = int'(bus.display_buf);
      r = int'(bus.render_buf);
      q = int'(dut.ready_q);
      check("go",      int'(bus.render_go),    m_go);
      check("ack",     int'(bus.render_ack),   m_ack);
      check("display", d,                      owner(R_DISP));
      check("render",  r,                      owner(R_RENDER));
      check("ready",   q,                      owner(R_READY));
      check("frames",  int'(bus.frame_count),  m_frame);
      check("repeats", int'(bus.repeat_count), m_rep);
      check("drops",   int'(bus.drop_count),   m_drop);
      check("permutation", int'(d < 3 && r < 3 && q < 3 && d != r && d != q && r != q), 1);
   endtask

   // One clock: model and DUT see the same inputs, then outputs are compared.
   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
      compare_model();
   endtask

   task automatic drive(input bit rst, input bit nf, input bit lk, input bit dn);
      Reset           = rst;
      bus.new_frame   = nf;
      bus.vsync_lock  = lk;
      bus.render_done = dn;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit rst, nf, lk, dn;
      int go, ack, disp, rend, frm, rep, drp;
   } vec_t;

   vec_t vecs [13];

   bit ag_busy, ag_drop;
   int ag_delay;

   initial begin
      drive(1, 0, 0, 0);

      // Reset, two mailbox completions (second drops the first), then a swap
      // and three repeats with nothing ready.
      vecs[0]  = '{1,0,0,0, 0,0,0,1,0,0,0};
      vecs[1]  = '{0,0,0,0, 1,0,0,1,0,0,0};
      vecs[2]  = '{0,0,0,0, 0,0,0,1,0,0,0};
      vecs[3]  = '{0,0,0,1, 0,1,0,2,0,0,0};
      vecs[4]  = '{0,0,0,1, 0,0,0,2,0,0,0};
      vecs[5]  = '{0,0,0,0, 0,0,0,2,0,0,0};
      vecs[6]  = '{0,0,0,0, 1,0,0,2,0,0,0};
      vecs[7]  = '{0,0,0,1, 0,1,0,1,0,0,1};
      vecs[8]  = '{0,0,0,0, 0,0,0,1,0,0,1};
      vecs[9]  = '{0,1,0,0, 1,0,2,1,1,0,1};
      vecs[10] = '{0,1,0,0, 0,0,2,1,1,1,1};
      vecs[11] = '{0,1,0,0, 0,0,2,1,1,2,1};
      vecs[12] = '{0,1,0,0, 0,0,2,1,1,3,1};

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].rst, vecs[i].nf, vecs[i].lk, vecs[i].dn);
         tick();
         check("tbl_go",      int'(bus.render_go),    vecs[i].go);
         check("tbl_ack",     int'(bus.render_ack),   vecs[i].ack);
         check("tbl_display", int'(bus.display_buf),  vecs[i].disp);
         check("tbl_render",  int'(bus.render_buf),   vecs[i].rend);
         check("tbl_frames",  int'(bus.frame_count),  vecs[i].frm);
         check("tbl_repeats", int'(bus.repeat_count), vecs[i].rep);
         check("tbl_drops",   int'(bus.drop_count),   vecs[i].drp);
      end

      // FIFO stall: second frame waits until a new_frame frees the ready slot.
      drive(1, 0, 1, 0); tick();
      drive(0, 0, 1, 0); tick();
      bus.render_done = 1; tick();
      check("fifo_first_ack", int'(bus.render_ack), 1);
      bus.render_done = 0; tick(); tick();
      bus.render_done = 1; tick(); tick(); tick();
      check("fifo_stall_state", int'(dut.state_q), int'(S_STALL));
      check("fifo_stall_noack", int'(bus.render_ack), 0);
      bus.new_frame = 1; tick();
      bus.new_frame = 0;
      check("fifo_release_ack", int'(bus.render_ack),  1);
      check("fifo_drops",       int'(bus.drop_count),  0);
      check("fifo_frames",      int'(bus.frame_count), 1);
      check("fifo_display",     int'(bus.display_buf), 1);
      check("fifo_render",      int'(bus.render_buf),  0);
      bus.render_done = 0; tick();

      // Simultaneous new_frame and render_done with a frame already waiting.
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      bus.render_done = 1; tick();
      bus.render_done = 0; tick(); tick();
      drive(0, 1, 0, 1); tick();
      check("sim_display", int'(bus.display_buf), 1);
      check("sim_ready",   int'(dut.ready_q),     2);
      check("sim_render",  int'(bus.render_buf),  0);
      check("sim_ack",     int'(bus.render_ack),  1);
      check("sim_drops",   int'(bus.drop_count),  0);
      drive(0, 0, 0, 0); tick();

      // Repeat saturation with nothing ever completed.
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      for (int i = 0; i < CNT_MAX; i++) begin
         bus.new_frame = 1; tick();
      end
      check("sat_reach", int'(bus.repeat_count), CNT_MAX);
      tick();
      check("sat_hold",    int'(bus.repeat_count), CNT_MAX);
      check("sat_display", int'(bus.display_buf),  0);
      bus.new_frame = 0;

      // Reset while the renderer reports done mid-frame.
      drive(1, 0, 0, 1); tick();
      check("rst_ack",     int'(bus.render_ack),   0);
      check("rst_go",      int'(bus.render_go),    0);
      check("rst_display", int'(bus.display_buf),  0);
      check("rst_render",  int'(bus.render_buf),   1);
      check("rst_repeats", int'(bus.repeat_count), 0);
      check("rst_state",   int'(dut.state_q),      int'(S_START));
      drive(0, 0, 0, 0); tick();
      check("rst_first_go", int'(bus.render_go), 1);

      // Randomized run: protocol-abiding renderer, random vblanks, mode flips.
      ag_busy = 0; ag_drop = 0; ag_delay = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         Reset = ($urandom_range(0, 399) == 0);
         bus.new_frame = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) bus.vsync_lock = !bus.vsync_lock;
         tick();
         if (Reset) begin
            bus.render_done = 0; ag_busy = 0; ag_drop = 0;
         end else begin
            if (bus.render_ack) begin
               ag_busy = 0;
               if ($urandom_range(0, 1) == 0) bus.render_done = 0;
               else ag_drop = 1;
            end else if (ag_drop) begin
               bus.render_done = 0; ag_drop = 0;
            end
            if (bus.render_go) begin
               ag_busy = 1; ag_delay = $urandom_range(0, 5);
            end else if (ag_busy && !bus.render_done) begin
               if (ag_delay == 0) bus.render_done = 1;
               else ag_delay--;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
